uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It detects frame completion from the receiver's idle/data-valid level, captures the received byte, and stores it in a synchronous FIFO. The buffered bytes are presented to the host side on a valid/ready stream, with occupancy flags and a sticky overflow indication.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 24 ++
 rtl/uart_rx_fifo.sv | 81 ++++++++
 tb/tb_uart_rx_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and FIFO operation encoding
package uart_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int OVERSAMPLE    = 16;
  localparam int RX_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    return fifo_op_e'({rd, wr});
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - register-array FIFO storage, sync write, async read
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally never reset; flags gate its validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte buffer with frame-end capture and
// show-ahead valid/ready output
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int   DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int   DEPTH      = uart_pkg::RX_FIFO_DEPTH,
  localparam int  ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_idle,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  rx_idle_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == COUNT_MAX);
  assign m_valid = ~empty;
  assign count   = count_q;

  // Rising edge of the idle level marks the end of the stop bit.
  assign push  = rx_idle & ~rx_idle_q;
  assign pop   = m_valid & m_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_idle_q <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
    end else begin
      rx_idle_q <= rx_idle;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case (fifo_op(wr_en, pop))
        FIFO_PUSH: count_q <= count_q + 1'b1;
        FIFO_POP:  count_q <= count_q - 1'b1;
        default:   count_q <= count_q;
      endcase
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr),
    .rd_data (m_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_idle = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_idle        (rx_idle),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send(input logic [7:0] b, input int low);
    rx_data = b;
    rx_idle = 1'b0;
    repeat (low) @(negedge clk);
    rx_idle = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single;
    send(8'hA5, 10);
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL single_m_valid got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL single_m_data got %h want a5", m_data); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty got %b want 0", empty); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_pop_empty got %b want 1", empty); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL single_pop_count got %0d want 0", count); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 16; i++) send(8'(i), 2);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_count got %0d want 16", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_overflow got %b want 0", overflow); end
    send(8'h11, 2);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", count); end
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin n_err++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, 8'(i)); end
      @(negedge clk);
    end
    m_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 2);
    rx_data = 8'h22;
    rx_idle = 1'b0;
    repeat (2) @(negedge clk);
    rx_idle = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow got %b want 0", overflow); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fpp_count got %0d want 16", count); end
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] exp;
      exp = (i == 16) ? 8'h22 : 8'h30 + 8'(i);
      n_cmp++; if (m_data !== exp) begin n_err++; $display("FAIL fpp_drain_%0d got %h want %h", i, m_data, exp); end
      @(negedge clk);
    end
    m_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fpp_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'h50 + 8'(i), 1);
      n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h50 + 8'(i) || count !== 5'd1) begin
        n_err++; $display("FAIL b2b_%0d got v=%b d=%h c=%0d want v=1 d=%h c=1", i, m_valid, m_data, count, 8'h50 + 8'(i));
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL b2b_count got %0d want 0", count); end
  endtask

  task automatic test_clear_collision;
    for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), 2);
    rx_data = 8'h77;
    rx_idle = 1'b0;
    repeat (2) @(negedge clk);
    rx_idle = 1'b1;
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL coll_overflow got %b want 1", overflow); end
    n_cmp++; if (m_data !== 8'h60) begin n_err++; $display("FAIL coll_head got %h want 60", m_data); end
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL coll_clear got %b want 0", overflow); end
  endtask

  task automatic test_reset_midframe;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL rst_flush_count got %0d want 0", count); end
    for (int i = 0; i < 3; i++) send(8'h80 + 8'(i), 2);
    n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL mid_pre_count got %0d want 3", count); end
    rx_idle = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_idle = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", count); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_m_valid got %b want 0", m_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow got %b want 0", overflow); end
    rx_data = 8'h99;
    rx_idle = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx_idle = 1'b1;
    @(negedge clk);
    n_cmp++; if (count !== 5'd1 || m_data !== 8'h99) begin n_err++; $display("FAIL post_rst_push got c=%0d d=%h want c=1 d=99", count, m_data); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_fill_overflow;
    test_full_push_pop;
    test_back_to_back;
    test_clear_collision;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
